// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_MEM = 2'b01,
    WB_SRC_PC4 = 2'b10,
    WB_SRC_IMM = 2'b11
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  function automatic logic [31:0] src_select(input wb_src_e src, input logic [31:0] alu,
                                             input logic [31:0] ld, input logic [31:0] pc4,
                                             input logic [31:0] imm);
    logic [31:0] res;
    case (src)
      WB_SRC_ALU: res = alu;
      WB_SRC_MEM: res = ld;
      WB_SRC_PC4: res = pc4;
      WB_SRC_IMM: res = imm;
      default:    res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load-data alignment and sign/zero extension (combinational).
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/halfword, then extend per funct3
  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    data   = rdata;
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    if (offset[1]) begin
      lane_h = rdata[31:16];
    end else begin
      lane_h = rdata[15:0];
    end
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'h000000, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data = {16'h0000, lane_h};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake, waiting on loads.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            wb_ready,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic            mem_mem_read,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_reg_write_src,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] mem_imm,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_reg_write,
  output logic [4:0]      wb_reg_write_rd,
  output logic [XLEN-1:0] wb_reg_write_data,
  output logic            wb_retire
`ifdef WB_INSTRET_EN
  , output logic [63:0]   wb_instret
`endif
);

  wb_state_e       state, next_state;
  logic            accept;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [XLEN-1:0] ld_alu, ld_pc4, ld_imm;
  logic            ld_reg_write;
  wb_src_e         ld_src;
  logic [XLEN-1:0] ext_data;
  logic            done, done_we;
  logic [4:0]      done_rd;
  logic [XLEN-1:0] done_data;

  assign wb_ready = (state == WB_IDLE);
  assign accept   = mem_valid && wb_ready;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .funct3 (ld_funct3),
    .offset (ld_alu[1:0]),
    .data   (ext_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and completion selection; a non-load naming the memory source falls back to ALU
  always_comb begin
    next_state = state;
    done       = 1'b0;
    done_we    = 1'b0;
    done_rd    = 5'd0;
    done_data  = 32'h0000_0000;
    case (state)
      WB_IDLE: begin
        if (accept) begin
          if (mem_mem_read) begin
            next_state = WB_WAIT_LOAD;
          end else begin
            next_state = WB_IDLE;
            done       = 1'b1;
            done_we    = mem_reg_write;
            done_rd    = mem_rd;
            done_data  = src_select(wb_src_e'(mem_reg_write_src), mem_alu_result,
                                    mem_alu_result, mem_pc_plus4, mem_imm);
          end
        end else begin
          next_state = WB_IDLE;
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          next_state = WB_IDLE;
          done       = 1'b1;
          done_we    = ld_reg_write;
          done_rd    = ld_rd;
          done_data  = src_select(ld_src, ld_alu, ext_data, ld_pc4, ld_imm);
        end else begin
          next_state = WB_WAIT_LOAD;
        end
      end
      default: next_state = WB_IDLE;
    endcase
  end

  // Capture everything a pending load needs to complete after the MEM/WB inputs move on
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd        <= 5'd0;
      ld_funct3    <= 3'b000;
      ld_alu       <= 32'h0000_0000;
      ld_pc4       <= 32'h0000_0000;
      ld_imm       <= 32'h0000_0000;
      ld_reg_write <= 1'b0;
      ld_src       <= WB_SRC_ALU;
    end else if (accept && mem_mem_read) begin
      ld_rd        <= mem_rd;
      ld_funct3    <= mem_funct3;
      ld_alu       <= mem_alu_result;
      ld_pc4       <= mem_pc_plus4;
      ld_imm       <= mem_imm;
      ld_reg_write <= mem_reg_write;
      ld_src       <= wb_src_e'(mem_reg_write_src);
    end
  end

  // Register-file write port; writes to x0 are suppressed but still retire
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write      <= 1'b0;
      wb_retire         <= 1'b0;
      wb_reg_write_rd   <= 5'd0;
      wb_reg_write_data <= 32'h0000_0000;
    end else begin
      wb_reg_write <= done && done_we && (done_rd != 5'd0);
      wb_retire    <= done;
      if (done) begin
        wb_reg_write_rd   <= done_rd;
        wb_reg_write_data <= done_data;
      end
    end
  end

`ifdef WB_INSTRET_EN
  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_instret <= 64'd0;
    end else if (done) begin
      wb_instret <= wb_instret + 64'd1;
    end
  end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RISC-V pipeline.
- Accepts one retiring instruction per handshake from the MEM/WB boundary.
- For loads, waits for the data-memory read response, then aligns and sign/zero-extends it.
- Selects the writeback source and drives the registered register-file write port (wb_reg_write, wb_reg_write_rd, wb_reg_write_data) consumed by the decode stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- mem_valid  input  1  MEM/WB instruction valid
- wb_ready  output  1  stage can accept an instruction this cycle
- mem_reg_write  input  1  instruction writes rd
- mem_rd  input  5  destination register
- mem_mem_read  input  1  instruction is a load
- mem_funct3  input  3  load width/sign code
- mem_reg_write_src  input  2  source select: 00 ALU, 01 load data, 10 PC+4, 11 immediate
- mem_alu_result  input  32  ALU result; also the load address
- mem_pc_plus4  input  32  link value
- mem_imm  input  32  immediate (LUI)
- dmem_rvalid  input  1  load response valid
- dmem_rdata  input  32  load response word, word-aligned
- wb_reg_write  output  1  register-file write enable
- wb_reg_write_rd  output  5  register-file write address
- wb_reg_write_data  output  32  register-file write data
- wb_retire  output  1  one-cycle pulse per retired instruction

Behaviour:
- Handshake: an instruction is accepted when mem_valid && wb_ready on a rising edge of clk.
- FSM states: IDLE, WAIT_LOAD.
  - IDLE: wb_ready=1.
    - Accept a non-load → stay in IDLE.
    - Accept a load (mem_mem_read=1) → go to WAIT_LOAD; latch rd, funct3, alu_result[1:0], reg_write and src.
  - WAIT_LOAD: wb_ready=0.
    - On dmem_rvalid → go to IDLE.
    - Otherwise hold with no timeout.
- dmem_rvalid is ignored in IDLE.
- Non-load latency: accept at edge N → write outputs valid for exactly the cycle after edge N.
- Load latency: rvalid sampled at edge M → write outputs valid for the cycle after edge M. The earliest next accept is edge M+1.
- Output registers:
  - wb_reg_write and wb_retire are single-cycle pulses; both are 0 when no completion occurs.
  - rd and data hold their last values otherwise.
- x0 rule: when rd=0, wb_reg_write=0 but wb_retire still pulses.
- Load extension uses off = alu_result[1:0]:
  - 000 LB: sign-extend byte rdata[8*off+:8].
  - 100 LBU: zero-extend the same byte.
  - 001 LH: sign-extend rdata[16*off[1]+:16]; off[0] is ignored.
  - 101 LHU: zero-extend the same halfword.
  - 010 LW, and reserved codes 011/110/111: the full word.
- Source select: a load with src≠01 writes the selected non-load source once rvalid arrives. The load still blocks.
- Reset: state=IDLE, wb_reg_write=0, wb_retire=0, wb_reg_write_rd=0, wb_reg_write_data=0. Reset mid-WAIT_LOAD drops the pending load; a later rvalid is ignored.
- Reset takes priority over a simultaneous accept or rvalid.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - Adds output wb_instret [63:0], a 64-bit retired-instruction counter.
  - The counter increments in the same edge that asserts wb_retire and wraps from 2^64-1 to 0.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - wb_src_e enum (WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_PC4=2'b10, WB_SRC_IMM=2'b11).
  - Load funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_e enum (WB_IDLE, WB_WAIT_LOAD).
- Sub-module load_extend (combinational): inputs rdata, funct3 and offset; output 32-bit extended data.

Test Plan:
1. Non-load: accept ALU src, rd=5, alu=0x0000_1234 → next cycle wb_reg_write=1, rd=5, data=0x0000_1234, wb_retire=1; one cycle later both pulses are 0.
2. LB: accept load rd=7, funct3=000, addr off=2; rvalid 3 cycles later with rdata=0x0080_0000 → data=0xFFFF_FF80. wb_ready=0 from the accept through the rvalid cycle.
3. LHU: off=2, rdata=0x8001_0000 → 0x0000_8001. LH with the same inputs → 0xFFFF_8001. LW with rdata=0xDEAD_BEEF → 0xDEAD_BEEF.
4. Back-to-back: non-loads to rd=1, 2, 3 with mem_valid held high → three consecutive write pulses in order with wb_ready=1 throughout. An ADD to rd=0 → wb_reg_write=0, wb_retire=1.
5. Reset mid-load: accept a load, assert rst for 1 cycle, then rvalid → no write, state IDLE, wb_ready=1.
6. With WB_INSTRET_EN: 10 retirements, including one rd=0 instruction → wb_instret=10.
